// File: rtl/aha_clk_switch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aha_clk_switch_pkg
// Brief    : Shared state encoding and index-width helper for the clock
//            switch controller.
// Revision : 1.0 - initial release
// ============================================================================
package aha_clk_switch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_OFF = 2'd1,
        ST_WAIT_ON  = 2'd2
    } state_t;

    function automatic int idx_w(input int num_clks);
        return (num_clks > 1) ? $clog2(num_clks) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aha_clk_sync2.sv
`default_nettype none
// ============================================================================
// Module   : aha_clk_sync2
// Brief    : Two-flop single-bit synchronizer, asynchronous active-low reset
//            to 0.
// Revision : 1.0 - initial release
// ============================================================================
module aha_clk_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/aha_clock_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aha_clock_switch_ctrl
// Brief    : Sequences glitch-free clock switch slices so exactly one source
//            feeds the muxed clock. Optional ack-wait timeout is built when
//            AHA_CLK_SWITCH_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module aha_clock_switch_ctrl
    import aha_clk_switch_pkg::*;
#(
    parameter int  NUM_CLKS  = 4,
    parameter int  RESET_SEL = 0,
    parameter int  TIMEOUT_W = 8,
    localparam int IDX_W     = idx_w(NUM_CLKS)
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                SEL_REQ_VALID,
    input  logic [IDX_W-1:0]    SEL_REQ_IDX,
    output logic                SEL_REQ_READY,
    input  logic [NUM_CLKS-1:0] SELECT_ACK,
    output logic [NUM_CLKS-1:0] SELECT_REQ,
    output logic [IDX_W-1:0]    CUR_SEL,
    output logic                BUSY,
    output logic                SWITCH_DONE,
    output logic                SEL_ERR,
    output logic                TIMEOUT_ERR
);

    localparam logic [NUM_CLKS-1:0] c_RESET_REQ = NUM_CLKS'(1) << RESET_SEL;
    localparam logic [IDX_W-1:0]    c_RESET_IDX = IDX_W'(RESET_SEL);
    localparam logic [31:0]         c_NUM_CLKS  = NUM_CLKS;

    logic [NUM_CLKS-1:0] w_ack_s;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLKS; gi++) begin : g_ack_sync
            aha_clk_sync2 u_sync (
                .clk   (CLK),
                .rst_n (RESETn),
                .i_d   (SELECT_ACK[gi]),
                .o_q   (w_ack_s[gi])
            );
        end
    endgenerate

    state_t              r_state,       w_state_nxt;
    logic [IDX_W-1:0]    r_target,      w_target_nxt;
    logic [IDX_W-1:0]    r_cur_sel,     w_cur_sel_nxt;
    logic [NUM_CLKS-1:0] r_select_req,  w_select_req_nxt;
    logic                r_switch_done, w_switch_done_nxt;
    logic                r_sel_err,     w_sel_err_nxt;
    logic                r_boot,        w_boot_nxt;

    logic                w_idx_oob;
    logic [NUM_CLKS-1:0] w_target_onehot;

    assign w_idx_oob       = ({{(32-IDX_W){1'b0}}, SEL_REQ_IDX} >= c_NUM_CLKS);
    assign w_target_onehot = NUM_CLKS'(1) << r_target;

    always_comb begin
        w_state_nxt       = r_state;
        w_target_nxt      = r_target;
        w_cur_sel_nxt     = r_cur_sel;
        w_select_req_nxt  = r_select_req;
        w_switch_done_nxt = 1'b0;
        w_sel_err_nxt     = 1'b0;
        w_boot_nxt        = r_boot;
        case (r_state)
            ST_IDLE: begin
                if (SEL_REQ_VALID) begin
                    if (w_idx_oob) begin
                        w_sel_err_nxt = 1'b1;
                    end else if (SEL_REQ_IDX == r_cur_sel) begin
                        w_switch_done_nxt = 1'b1;
                    end else begin
                        w_target_nxt     = SEL_REQ_IDX;
                        w_select_req_nxt = '0;
                        w_state_nxt      = ST_WAIT_OFF;
                    end
                end
            end
            ST_WAIT_OFF: begin
                // Every slice must report gated off before the new one is asked for.
                if (w_ack_s == '0) begin
                    w_select_req_nxt = w_target_onehot;
                    w_state_nxt      = ST_WAIT_ON;
                end
            end
            ST_WAIT_ON: begin
                if (w_ack_s[r_target]) begin
                    w_cur_sel_nxt     = r_target;
                    w_state_nxt       = ST_IDLE;
                    w_switch_done_nxt = !r_boot;
                    w_boot_nxt        = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state       <= ST_WAIT_ON;
            r_target      <= c_RESET_IDX;
            r_cur_sel     <= c_RESET_IDX;
            r_select_req  <= c_RESET_REQ;
            r_switch_done <= 1'b0;
            r_sel_err     <= 1'b0;
            r_boot        <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_target      <= w_target_nxt;
            r_cur_sel     <= w_cur_sel_nxt;
            r_select_req  <= w_select_req_nxt;
            r_switch_done <= w_switch_done_nxt;
            r_sel_err     <= w_sel_err_nxt;
            r_boot        <= w_boot_nxt;
        end
    end

`ifdef AHA_CLK_SWITCH_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_tmo_cnt,     w_tmo_cnt_nxt;
    logic                 r_timeout_err, w_timeout_err_nxt;

    always_comb begin
        w_tmo_cnt_nxt     = r_tmo_cnt;
        w_timeout_err_nxt = r_timeout_err;
        if (w_state_nxt != r_state) begin
            w_tmo_cnt_nxt = '0;
        end else if ((r_state != ST_IDLE) && (r_tmo_cnt != '1)) begin
            w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
        end
        // Flag only; the FSM keeps waiting rather than forcing a select.
        if ((w_state_nxt == r_state) && (r_state != ST_IDLE) && (w_tmo_cnt_nxt == '1)) begin
            w_timeout_err_nxt = 1'b1;
        end
        if ((r_state == ST_IDLE) && SEL_REQ_VALID && !w_idx_oob) begin
            w_timeout_err_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tmo_cnt     <= w_tmo_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign TIMEOUT_ERR = r_timeout_err;
`else
    // No counter in this build; the expression is constant 0 for any legal width.
    assign TIMEOUT_ERR = (TIMEOUT_W < 0);
`endif

    assign SEL_REQ_READY = (r_state == ST_IDLE);
    assign BUSY          = (r_state != ST_IDLE);
    assign SELECT_REQ    = r_select_req;
    assign CUR_SEL       = r_cur_sel;
    assign SWITCH_DONE   = r_switch_done;
    assign SEL_ERR       = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_aha_clock_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aha_clock_switch_ctrl
// Brief    : Self-checking bench for aha_clock_switch_ctrl (4-slice main
//            instance plus a 3-slice instance for out-of-range indices).
//            Timeout checks need AHA_CLK_SWITCH_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aha_clock_switch_ctrl;

    logic clk = 1'b0;
    logic src_clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    always #7 src_clk = ~src_clk;

    // main instance, NUM_CLKS = 4
    logic       valid, ready, busy, done, err, tmo;
    logic [1:0] idx, cur;
    logic [3:0] ack, req, stuck;
    logic [3:0] sh1 = '0, sh2 = '0, sh3 = '0;
    always @(posedge src_clk) begin
        sh1 <= req; sh2 <= sh1; sh3 <= sh2;
    end
    assign ack = sh3 | stuck;

    aha_clock_switch_ctrl #(.NUM_CLKS(4), .RESET_SEL(0), .TIMEOUT_W(4)) dut (
        .CLK(clk), .RESETn(rst_n), .SEL_REQ_VALID(valid), .SEL_REQ_IDX(idx),
        .SEL_REQ_READY(ready), .SELECT_ACK(ack), .SELECT_REQ(req), .CUR_SEL(cur),
        .BUSY(busy), .SWITCH_DONE(done), .SEL_ERR(err), .TIMEOUT_ERR(tmo)
    );

    // out-of-range instance, NUM_CLKS = 3
    logic       valid3, ready3, busy3, done3, err3, tmo3;
    logic [1:0] idx3, cur3;
    logic [2:0] ack3, req3;
    logic [2:0] t1 = '0, t2 = '0, t3 = '0;
    always @(posedge src_clk) begin
        t1 <= req3; t2 <= t1; t3 <= t2;
    end
    assign ack3 = t3;

    aha_clock_switch_ctrl #(.NUM_CLKS(3), .RESET_SEL(0), .TIMEOUT_W(4)) dut3 (
        .CLK(clk), .RESETn(rst_n), .SEL_REQ_VALID(valid3), .SEL_REQ_IDX(idx3),
        .SEL_REQ_READY(ready3), .SELECT_ACK(ack3), .SELECT_REQ(req3), .CUR_SEL(cur3),
        .BUSY(busy3), .SWITCH_DONE(done3), .SEL_ERR(err3), .TIMEOUT_ERR(tmo3)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       done;
        logic       err;
        logic [1:0] cur;
        logic [3:0] req;
    } exp_t;

    typedef struct packed {
        logic [1:0] idx;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;

    // Completion events pop the scoreboard; any pulse with nothing pending is an error.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_onehot", 32'($countones(req) <= 1), 1);
            if (done || err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {30'd0, done, err}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ev_done", done, mon_e.done);
                    chk("ev_err",  err,  mon_e.err);
                    chk("ev_cur",  cur,  mon_e.cur);
                    chk("ev_req",  req,  mon_e.req);
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int k = 0;
        @(negedge clk);
        while (!ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(name, ready, 1);
    endtask

    task automatic send(input logic [1:0] i, input exp_t e);
        wait_ready("send_ready");
        sb.push_back(e);
        valid = 1'b1;
        idx   = i;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int   k;
        int   gap;
        logic hold_bad;
        logic [3:0] first_on;

        tbl[0] = '{2'd1, '{1'b1, 1'b0, 2'd1, 4'b0010}};
        tbl[1] = '{2'd1, '{1'b1, 1'b0, 2'd1, 4'b0010}};
        tbl[2] = '{2'd3, '{1'b1, 1'b0, 2'd3, 4'b1000}};
        tbl[3] = '{2'd0, '{1'b1, 1'b0, 2'd0, 4'b0001}};
        tbl[4] = '{2'd2, '{1'b1, 1'b0, 2'd2, 4'b0100}};
        tbl[5] = '{2'd2, '{1'b1, 1'b0, 2'd2, 4'b0100}};

        valid = 1'b0; idx = '0; stuck = '0; valid3 = 1'b0; idx3 = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_req",   req,   4'b0001);
        chk("rst_busy",  busy,  1);
        chk("rst_ready", ready, 0);
        chk("rst_cur",   cur,   0);
        chk("rst_done",  done,  0);
        chk("rst_tmo",   tmo,   0);
        rst_n = 1'b1;
        wait_ready("boot_ready");
        chk("boot_busy", busy, 0);
        chk("boot_cur",  cur,  0);
        chk("boot_req",  req,  4'b0001);

        // switch 0 -> 2, observing the break-before-make sequence
        sb.push_back('{1'b1, 1'b0, 2'd2, 4'b0100});
        valid = 1'b1; idx = 2'd2;
        @(posedge clk);
        #1 valid = 1'b0;
        k = 0; gap = 0; hold_bad = 1'b0; first_on = '0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
            if (!done && cur != 2'd0) hold_bad = 1'b1;
            if (req == 4'b0000 && first_on == 4'b0000) gap++;
            else if (first_on == 4'b0000) first_on = req;
        end
        chk("sw2_done_seen", done, 1);
        chk("sw2_off_gap",   32'(gap >= 3), 1);
        chk("sw2_first_on",  first_on, 4'b0100);
        chk("sw2_cur_hold",  hold_bad, 0);

        // same index: immediate done, select unchanged
        send(2'd2, '{1'b1, 1'b0, 2'd2, 4'b0100});
        @(negedge clk);
        chk("same_done",  done,  1);
        chk("same_req",   req,   4'b0100);
        chk("same_ready", ready, 1);

        for (int i = 0; i < 6; i++) send(tbl[i].idx, tbl[i].e);

        // VALID held through a switch: accepted only once back in IDLE
        send(2'd1, '{1'b1, 1'b0, 2'd1, 4'b0010});
        sb.push_back('{1'b1, 1'b0, 2'd3, 4'b1000});
        valid = 1'b1; idx = 2'd3;
        k = 0;
        while (!ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("held_ready",      ready, 1);
        chk("held_ready_done", done,  1);
        chk("held_cur",        cur,   1);
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        chk("held_taken_busy", busy, 1);
        wait_ready("held_final_ready");
        chk("held_final_cur", cur, 3);

        // out-of-range index on the 3-slice instance
        k = 0;
        while (!ready3 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("d3_ready", ready3, 1);
        valid3 = 1'b1; idx3 = 2'd3;
        @(posedge clk);
        #1 valid3 = 1'b0;
        @(negedge clk);
        chk("d3_err",   err3,   1);
        chk("d3_done",  done3,  0);
        chk("d3_req",   req3,   3'b001);
        chk("d3_cur",   cur3,   0);
        chk("d3_ready_after", ready3, 1);
        @(negedge clk);
        chk("d3_err_pulse", err3, 0);
        chk("d3_busy", busy3, 0);
        chk("d3_tmo",  tmo3,  0);

        // mid-switch asynchronous reset (with timeout when built)
        wait_ready("pre_reset_ready");
`ifdef AHA_CLK_SWITCH_TIMEOUT_EN
        stuck = 4'b0010;
        repeat (3) @(negedge clk);
        valid = 1'b1; idx = 2'd0;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("tmo_before", tmo, 0);
        @(negedge clk);
        chk("tmo_set", tmo, 1);
        repeat (4) @(negedge clk);
        chk("tmo_sticky",   tmo, 1);
        chk("tmo_no_force", req, 4'b0000);
`else
        valid = 1'b1; idx = 2'd0;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_req_off", req, 4'b0000);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",  req,  4'b0001);
        chk("arst_tmo",  tmo,  0);
        chk("arst_busy", busy, 1);
        chk("arst_cur",  cur,  0);
        sb.delete();
        stuck = '0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("reboot_ready");
        chk("reboot_cur", cur, 0);
        chk("reboot_req", req, 4'b0001);

        send(2'd2, '{1'b1, 1'b0, 2'd2, 4'b0100});
        wait_ready("final_ready");
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
